// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the datapath: the IR and Stop
// inputs plus every strobe, register-select control and ALU opcode.
interface control_sequencer_if #(
    parameter int OPW = 5
);
    logic [31:0]    IR;
    logic           Stop;
    logic           PCout;
    logic           MARin;
    logic           IncPC;
    logic           ZLowIn;
    logic           ZLowOut;
    logic           PCin;
    logic           Read;
    logic           MDRin;
    logic           MDRout;
    logic           IRin;
    logic           Yin;
    logic           Gra;
    logic           Grb;
    logic           Grc;
    logic           Rin;
    logic           Rout;
    logic [OPW-1:0] ALUop;
    logic           Run;
    logic           Illegal;

    modport master (
        input  IR, Stop,
        output PCout, MARin, IncPC, ZLowIn, ZLowOut, PCin, Read, MDRin, MDRout,
               IRin, Yin, Gra, Grb, Grc, Rin, Rout, ALUop, Run, Illegal
    );

    modport slave (
        output IR, Stop,
        input  PCout, MARin, IncPC, ZLowIn, ZLowOut, PCin, Read, MDRin, MDRout,
               IRin, Yin, Gra, Grb, Grc, Rin, Rout, ALUop, Run, Illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: three fetch states then up to three execute states,
// decoding register-ALU ops, nop, halt and the Stop request from the IR.
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int REGW = 4
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALTED
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    state_t         state_reg;
    state_t         state_next;
    state_t         end_state;
    logic [OPW-1:0] opcode;
    logic           is_rtype;
    logic           is_unary;
    logic           is_nop;
    logic           is_halt;

    // Register fields are routed by the datapath's select-and-encode logic, not here.
    logic [3*REGW-1:0]          unused_reg_fields;
    logic [31-OPW-3*REGW:0]     unused_low_bits;
    assign unused_reg_fields = bus.IR[31-OPW -: 3*REGW];
    assign unused_low_bits   = bus.IR[31-OPW-3*REGW:0];

    assign opcode   = bus.IR[31 -: OPW];
    assign is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
    assign is_unary = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_nop   = (opcode == OP_NOP);
    assign is_halt  = (opcode == OP_HALT);

    // Stop is only honoured at the instruction boundary.
    assign end_state = bus.Stop ? S_HALTED : S_T0;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg <= S_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bus.PCout   = 1'b0;
        bus.MARin   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.ZLowIn  = 1'b0;
        bus.ZLowOut = 1'b0;
        bus.PCin    = 1'b0;
        bus.Read    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.MDRout  = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;
        bus.ALUop   = '0;
        bus.Run     = 1'b0;
        bus.Illegal = 1'b0;

        case (state_reg)
            S_RST: begin
                state_next = S_T0;
            end
            S_T0: begin
                bus.Run    = 1'b1;
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.ZLowIn = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                bus.Run     = 1'b1;
                bus.ZLowOut = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                state_next  = S_T2;
            end
            S_T2: begin
                bus.Run    = 1'b1;
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                bus.Run = 1'b1;
                if (is_rtype) begin
                    bus.Grb    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Yin    = 1'b1;
                    state_next = S_T4;
                end else if (is_unary) begin
                    bus.Grb    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.ALUop  = opcode;
                    bus.ZLowIn = 1'b1;
                    state_next = S_T4;
                end else if (is_halt) begin
                    state_next = S_HALTED;
                end else begin
                    bus.Illegal = !is_nop;
                    state_next  = end_state;
                end
            end
            S_T4: begin
                bus.Run = 1'b1;
                if (is_rtype) begin
                    bus.Grc    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.ALUop  = opcode;
                    bus.ZLowIn = 1'b1;
                    state_next = S_T5;
                end else if (is_unary) begin
                    bus.ZLowOut = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                    state_next  = end_state;
                end else begin
                    // IR changed under an executing op: close the instruction quietly.
                    state_next = end_state;
                end
            end
            S_T5: begin
                bus.Run     = 1'b1;
                bus.ZLowOut = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
                state_next  = end_state;
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            default: begin
                state_next = S_RST;
            end
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed walk-through with literal expectations,
// then random instruction streams checked every cycle against a schedule model.
module tb_control_sequencer;
    // Output vector packing: {Run, Illegal, PCout, MARin, IncPC, ZLowIn, ZLowOut,
    // PCin, Read, MDRin, MDRout, IRin, Yin, Gra, Grb, Grc, Rin, Rout, ALUop[4:0]}
    localparam logic [22:0] RUN    = 23'h1 << 22;
    localparam logic [22:0] ILL    = 23'h1 << 21;
    localparam logic [22:0] PCOUT  = 23'h1 << 20;
    localparam logic [22:0] MARIN  = 23'h1 << 19;
    localparam logic [22:0] INCPC  = 23'h1 << 18;
    localparam logic [22:0] ZLI    = 23'h1 << 17;
    localparam logic [22:0] ZLO    = 23'h1 << 16;
    localparam logic [22:0] PCIN   = 23'h1 << 15;
    localparam logic [22:0] READ   = 23'h1 << 14;
    localparam logic [22:0] MDRIN  = 23'h1 << 13;
    localparam logic [22:0] MDROUT = 23'h1 << 12;
    localparam logic [22:0] IRIN   = 23'h1 << 11;
    localparam logic [22:0] YIN    = 23'h1 << 10;
    localparam logic [22:0] GRA    = 23'h1 << 9;
    localparam logic [22:0] GRB    = 23'h1 << 8;
    localparam logic [22:0] GRC    = 23'h1 << 7;
    localparam logic [22:0] RIN    = 23'h1 << 6;
    localparam logic [22:0] ROUT   = 23'h1 << 5;

    localparam logic [22:0] F0 = RUN | PCOUT | MARIN | INCPC | ZLI;
    localparam logic [22:0] F1 = RUN | ZLO | PCIN | READ | MDRIN;
    localparam logic [22:0] F2 = RUN | MDROUT | IRIN;

    localparam logic [31:0] IR_NOT  = 32'h922B8000;
    localparam logic [31:0] IR_ADD  = 32'h18A18000;
    localparam logic [31:0] IR_ILL  = 32'hF8000000;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    control_sequencer_if #(.OPW(5)) bus();

    control_sequencer #(.OPW(5), .REGW(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    logic [22:0] dut_vec;
    assign dut_vec = {bus.Run, bus.Illegal, bus.PCout, bus.MARin, bus.IncPC, bus.ZLowIn,
                      bus.ZLowOut, bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
                      bus.Yin, bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout, bus.ALUop};

    int compared   = 0;
    int mismatched = 0;

    // Model: position within the current instruction's cycle schedule.
    logic m_in_reset = 1'b1;
    logic m_halted   = 1'b0;
    int   m_pos      = 0;

    function automatic int op_class(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6: return 0;   // two-operand ALU
            5'd17, 5'd18:           return 1;   // unary ALU
            5'd26:                  return 2;   // nop
            5'd27:                  return 3;   // halt
            default:                return 4;   // illegal
        endcase
    endfunction

    function automatic int exec_len(input logic [4:0] op);
        case (op_class(op))
            0:       return 3;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [22:0] model_vec(input logic [31:0] ir);
        logic [4:0]  op;
        logic [22:0] alu;
        int          cls;
        op  = ir[31:27];
        alu = {18'd0, op};
        cls = op_class(op);
        if (m_in_reset || m_halted) return 23'd0;
        case (m_pos)
            0: return F0;
            1: return F1;
            2: return F2;
            3: case (cls)
                   0:       return RUN | GRB | ROUT | YIN;
                   1:       return RUN | GRB | ROUT | ZLI | alu;
                   4:       return RUN | ILL;
                   default: return RUN;
               endcase
            4: return (cls == 0) ? (RUN | GRC | ROUT | ZLI | alu) : (RUN | ZLO | GRA | RIN);
            default: return RUN | ZLO | GRA | RIN;
        endcase
    endfunction

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_in_reset <= 1'b1;
            m_halted   <= 1'b0;
            m_pos      <= 0;
        end else if (m_in_reset) begin
            m_in_reset <= 1'b0;
            m_pos      <= 0;
        end else if (!m_halted) begin
            if (m_pos == 2 + exec_len(bus.IR[31:27])) begin
                if (op_class(bus.IR[31:27]) == 3 || bus.Stop) m_halted <= 1'b1;
                else m_pos <= 0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    always @(negedge clock) begin
        logic [22:0] exp_v;
        exp_v = model_vec(bus.IR);
        compared = compared + 1;
        if (dut_vec !== exp_v) begin
            mismatched = mismatched + 1;
            $display("FAIL cycle_model t=%0t: got %h expected %h (pos %0d IR %h)",
                     $time, dut_vec, exp_v, m_pos, bus.IR);
        end
    end

    task automatic check(input string name, input logic [22:0] exp_v);
        compared = compared + 1;
        if (dut_vec !== exp_v) begin
            mismatched = mismatched + 1;
            $display("FAIL %s: got %h expected %h", name, dut_vec, exp_v);
        end
    endtask

    task automatic expect_now(input string name, input logic [22:0] exp_v);
        @(negedge clock);
        #1;
        check(name, exp_v);
    endtask

    task automatic reset_pulse(input string name);
        clear = 1'b1;
        #1;
        check(name, 23'd0);
        @(posedge clock);
        #2;
        clear = 1'b0;
        expect_now({name, "_rst"}, 23'd0);
        expect_now({name, "_t0"}, F0);
    endtask

    initial begin
        logic [4:0]  ops [8];
        logic [31:0] r;
        logic [4:0]  op;
        ops = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd17, 5'd18, 5'd26, 5'd27};

        bus.IR   = 32'd0;
        bus.Stop = 1'b0;
        clear    = 1'b1;
        repeat (2) @(posedge clock);
        #2;
        clear = 1'b0;
        expect_now("rst_idle", 23'd0);
        expect_now("t0_after_reset", F0);

        bus.IR = IR_NOT;
        expect_now("not_t1", F1);
        expect_now("not_t2", F2);
        expect_now("not_t3", RUN | GRB | ROUT | ZLI | 23'h12);
        expect_now("not_t4", RUN | ZLO | GRA | RIN);
        expect_now("not_next_t0", F0);

        bus.IR = IR_ADD;
        expect_now("add_t1", F1);
        expect_now("add_t2", F2);
        expect_now("add_t3", RUN | GRB | ROUT | YIN);
        expect_now("add_t4", RUN | GRC | ROUT | ZLI | 23'h03);
        expect_now("add_t5", RUN | ZLO | GRA | RIN);
        expect_now("add_next_t0", F0);

        bus.IR = IR_ILL;
        expect_now("ill_t1", F1);
        expect_now("ill_t2", F2);
        expect_now("ill_t3", RUN | ILL);
        expect_now("ill_next_t0", F0);

        bus.IR = IR_NOP;
        expect_now("nop_t1", F1);
        expect_now("nop_t2", F2);
        expect_now("nop_t3", RUN);
        expect_now("nop_next_t0", F0);

        bus.IR = IR_ADD;
        expect_now("stop_add_t1", F1);
        bus.Stop = 1'b1;
        expect_now("stop_add_t2", F2);
        expect_now("stop_add_t3", RUN | GRB | ROUT | YIN);
        expect_now("stop_add_t4", RUN | GRC | ROUT | ZLI | 23'h03);
        expect_now("stop_add_t5", RUN | ZLO | GRA | RIN);
        repeat (3) expect_now("stop_halted", 23'd0);
        bus.Stop = 1'b0;
        reset_pulse("stop_recover");

        bus.IR = IR_HALT;
        expect_now("halt_t1", F1);
        expect_now("halt_t2", F2);
        expect_now("halt_t3", RUN);
        repeat (10) expect_now("halt_hold", 23'd0);
        reset_pulse("halt_recover");

        bus.IR = IR_ADD;
        expect_now("abort_t1", F1);
        expect_now("abort_t2", F2);
        expect_now("abort_t3", RUN | GRB | ROUT | YIN);
        expect_now("abort_t4", RUN | GRC | ROUT | ZLI | 23'h03);
        reset_pulse("abort_clear");
        expect_now("abort_restart_t1", F1);

        // Random instruction streams with random Stop and clear.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clock);
            #2;
            if (clear) begin
                clear = 1'b0;
            end else if (m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 150) == 0)) begin
                clear = 1'b1;
            end else begin
                if (m_pos == 2) begin
                    r  = $urandom;
                    op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : r[31:27];
                    bus.IR = {op, r[26:0]};
                end else if (m_pos < 2) begin
                    bus.IR = $urandom;
                end
                bus.Stop = ($urandom_range(0, 9) == 0);
            end
        end

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
